// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM with memory-wait timeout.
// Drives datapath selects/enables; PC-on-branch gating on zero is external.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       ext_sel,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    IEX    = 4'd9,
    IWB    = 4'd10,
    JMP    = 4'd11
  } state_t;

  state_t        cur, nxt;
  logic [5:0]    op_q;
  logic [CW-1:0] wait_cnt;
  logic          err_q, ill_q;
  logic          dec_ill, waiting, timeout;
  logic [1:0]    imm_aop;
  logic          imm_ext;
  logic          zero_unused;

  // Branch qualification by zero is done outside this block.
  assign zero_unused = zero;

  assign imm_aop = (op_q == OP_ORI)  ? 2'b11 :
                   (op_q == OP_ANDI) ? 2'b10 : 2'b00;
  assign imm_ext = (op_q == OP_ADDI);

  always_comb begin
    nxt           = cur;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    ext_sel       = 1'b1;
    dec_ill       = 1'b0;
    waiting       = 1'b0;
    timeout       = 1'b0;
    if (rst) begin
      ext_sel = 1'b0;
    end else if (!err_q) begin
      // The cycle after a timeout is an idle FETCH bubble.
      case (cur)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          unique case (1'b1)
            (opcode == OP_LW) || (opcode == OP_SW): nxt = MEMADR;
            (opcode == OP_R): nxt = REX;
            (opcode == OP_BEQ): nxt = BEQ;
            (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
            (opcode == OP_ORI): nxt = IEX;
            (opcode == OP_J): nxt = JMP;
            default: begin
              nxt     = FETCH;
              dec_ill = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          nxt       = (op_q == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) nxt = MEMWB;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          nxt        = FETCH;
        end
        MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
          if (mem_ready) nxt = FETCH;
        end
        REX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          nxt       = RWB;
        end
        RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          nxt       = FETCH;
        end
        BEQ: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_src        = 2'b01;
          pc_write_cond = 1'b1;
          nxt           = FETCH;
        end
        IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = imm_aop;
          ext_sel   = imm_ext;
          nxt       = IWB;
        end
        IWB: begin
          reg_write = 1'b1;
          alu_op    = imm_aop;
          ext_sel   = imm_ext;
          nxt       = FETCH;
        end
        JMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          nxt      = FETCH;
        end
        default: nxt = FETCH;
      endcase
      waiting = mem_req & ~mem_ready;
      timeout = waiting && (wait_cnt == LAST);
      if (timeout) nxt = FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur      <= FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      cur   <= nxt;
      err_q <= timeout;
      ill_q <= dec_ill;
      if (cur == DECODE) op_q <= opcode;
      if ((nxt != cur) || timeout) wait_cnt <= '0;
      else if (waiting) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign state      = cur;
  assign illegal_op = ill_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: route-queue reference model
// checked every cycle, plus directed per-instruction traces.
module tb_mips_multicycle_control;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       pc_write, pc_write_cond, ir_write, reg_write;
  logic       mem_req, mem_we, i_or_d, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       ext_sel, illegal_op, mem_err;
  logic [3:0] state;

  int passed = 0;
  int total  = 0;

  mips_multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .zero(zero), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .reg_write(reg_write), .mem_req(mem_req),
    .mem_we(mem_we), .i_or_d(i_or_d), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .ext_sel(ext_sel), .state(state), .illegal_op(illegal_op),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
  endtask

  typedef struct packed {
    logic pcw, pcwc, irw, rw, mr, mw, iod, rd, m2r, asa;
    logic [1:0] asb, aop, psrc;
    logic ext;
  } ctl_t;

  // Reference model: per-instruction route of states after DECODE.
  int         m_st = 0;
  int         m_cnt = 0;
  logic       m_err = 1'b0;
  logic       m_ill = 1'b0;
  logic [5:0] m_op = '0;
  int         route[$];
  int         m_nxt;
  logic       e_n, i_n;

  function automatic void plan(input int a, input int b, input int c);
    if (a != 0) route.push_back(a);
    if (b != 0) route.push_back(b);
    if (c != 0) route.push_back(c);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_cnt = 0; m_err = 1'b0; m_ill = 1'b0;
      route.delete();
    end else begin
      e_n = 1'b0; i_n = 1'b0; m_nxt = m_st;
      if (m_err) m_nxt = 0;
      else if ((m_st == 0 || m_st == 3 || m_st == 5) && !mem_ready) begin
        m_cnt++;
        if (m_cnt == TMO) begin
          e_n = 1'b1; m_nxt = 0; route.delete();
        end
      end else if (m_st == 0) m_nxt = 1;
      else begin
        if (m_st == 1) begin
          m_op = opcode;
          case (opcode)
            6'h23: plan(2, 3, 4);
            6'h2b: plan(2, 5, 0);
            6'h00: plan(6, 7, 0);
            6'h04: plan(8, 0, 0);
            6'h08, 6'h0c, 6'h0d: plan(9, 10, 0);
            6'h02: plan(11, 0, 0);
            default: i_n = 1'b1;
          endcase
        end
        m_nxt = (route.size() != 0) ? route.pop_front() : 0;
      end
      if (m_nxt != m_st || e_n) m_cnt = 0;
      m_st = m_nxt; m_err = e_n; m_ill = i_n;
    end
  end

  function automatic ctl_t expect_ctl(input int st, input logic rdy);
    ctl_t c;
    c = '0;
    c.ext = 1'b1;
    if (rst) begin
      c.ext = 1'b0;
      return c;
    end
    if (m_err) return c;
    case (st)
      0: begin
        c.mr = 1; c.asb = 2'b01;
        if (rdy) begin c.irw = 1; c.pcw = 1; end
      end
      1: c.asb = 2'b11;
      2: begin c.asa = 1; c.asb = 2'b10; end
      3: begin c.mr = 1; c.iod = 1; end
      4: begin c.rw = 1; c.m2r = 1; end
      5: begin c.mr = 1; c.mw = 1; c.iod = 1; end
      6: begin c.asa = 1; c.aop = 2'b10; end
      7: begin c.rw = 1; c.rd = 1; end
      8: begin c.asa = 1; c.aop = 2'b01; c.psrc = 2'b01; c.pcwc = 1; end
      9, 10: begin
        if (st == 9) begin c.asa = 1; c.asb = 2'b10; end
        else c.rw = 1;
        case (m_op)
          6'h0d: begin c.aop = 2'b11; c.ext = 1'b0; end
          6'h0c: begin c.aop = 2'b10; c.ext = 1'b0; end
          default: begin c.aop = 2'b00; c.ext = 1'b1; end
        endcase
      end
      11: begin c.pcw = 1; c.psrc = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  ctl_t dut_ctl;
  assign dut_ctl = '{pc_write, pc_write_cond, ir_write, reg_write, mem_req,
                     mem_we, i_or_d, reg_dst, mem_to_reg, alu_src_a,
                     alu_src_b, alu_op, pc_src, ext_sel};

  always @(negedge clk) begin
    chk("model_ctl", 32'(dut_ctl), 32'(expect_ctl(m_st, mem_ready)));
    chk("model_state", 32'(state), rst ? 32'd0 : 32'(m_st));
    chk("model_ill", 32'(illegal_op), rst ? 32'd0 : 32'(m_ill));
    chk("model_err", 32'(mem_err), rst ? 32'd0 : 32'(m_err));
  end

  typedef struct {
    int st;
    logic mreq, rw, m2r, rd, ext, pcw, pcwc, irw, ill, err;
    logic [1:0] aop, psrc;
  } rec_t;
  rec_t trace[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [5:0] op, input int n,
                     input logic [31:0] rdy, input logic scr);
    rec_t r;
    opcode = op;
    trace.delete();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy[i];
      if (scr && i == 2) opcode = 6'h3f;
      #1;
      r.st = int'(state); r.mreq = mem_req; r.rw = reg_write;
      r.m2r = mem_to_reg; r.rd = reg_dst; r.ext = ext_sel;
      r.pcw = pc_write; r.pcwc = pc_write_cond; r.irw = ir_write;
      r.ill = illegal_op; r.err = mem_err; r.aop = alu_op; r.psrc = pc_src;
      trace.push_back(r);
      tick();
    end
  endtask

  task automatic chk_path(input string n, input int cnt,
                          input logic [63:0] codes);
    for (int i = 0; i < cnt; i++)
      chk(n, 32'(trace[i].st), 32'(codes[4*i +: 4]));
  endtask

  int   waits;
  logic irw_seen;

  initial begin
    tick(); tick();
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ext_sel", 32'(ext_sel), 32'd0);
    mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("post_rst_mem_req", 32'(mem_req), 32'd1);

    run(6'h23, 5, '1, 1'b0);
    chk_path("lw_path", 5, 64'h43210);
    for (int i = 0; i < 5; i++)
      chk("lw_wb", 32'(trace[i].rw & trace[i].m2r), 32'(i == 4));

    run(6'h23, 8, 32'hC7, 1'b0);
    chk_path("lw_slow_path", 8, 64'h43333210);

    run(6'h2b, 4, '1, 1'b0);
    chk_path("sw_path", 4, 64'h5210);

    run(6'h00, 4, '1, 1'b0);
    chk_path("r_path", 4, 64'h7610);
    chk("r_wb", 32'({trace[3].rw, trace[3].rd}), 32'h3);

    run(6'h0d, 4, '1, 1'b1);
    chk_path("ori_path", 4, 64'hA910);
    for (int i = 2; i < 4; i++) begin
      chk("ori_ext", 32'(trace[i].ext), 32'd0);
      chk("ori_aop", 32'(trace[i].aop), 32'd3);
    end

    run(6'h08, 4, '1, 1'b0);
    for (int i = 2; i < 4; i++) begin
      chk("addi_ext", 32'(trace[i].ext), 32'd1);
      chk("addi_aop", 32'(trace[i].aop), 32'd0);
    end

    run(6'h0c, 4, '1, 1'b1);
    chk("andi_ext", 32'(trace[3].ext), 32'd0);
    chk("andi_aop", 32'(trace[3].aop), 32'd2);

    for (int z = 0; z < 2; z++) begin
      zero = z[0];
      run(6'h04, 3, '1, 1'b0);
      chk_path("beq_path", 3, 64'h810);
      chk("beq_pcwc", 32'(trace[2].pcwc), 32'd1);
      chk("beq_psrc", 32'(trace[2].psrc), 32'd1);
      chk("beq_pcw", 32'(trace[2].pcw), 32'd0);
    end

    run(6'h3f, 3, '1, 1'b0);
    chk_path("ill_path", 3, 64'h010);
    chk("ill_pulse", 32'({trace[0].ill, trace[1].ill, trace[2].ill}), 32'h1);
    chk("ill_decode_idle", 32'(trace[1].mreq | trace[1].rw), 32'd0);
    run(6'h02, 2, '1, 1'b0);
    chk_path("j_path", 2, 64'hB1);
    chk("ill_once", 32'(trace[0].ill), 32'd0);
    chk("j_pc", 32'({trace[1].pcw, trace[1].psrc}), 32'h6);

    run(6'h02, 6, 32'h38, 1'b0);
    chk_path("fetch_wait_path", 6, 64'hB10000);
    chk("fetch_wait_irw", 32'({trace[0].irw, trace[1].irw, trace[2].irw,
                                trace[3].irw}), 32'h1);

    mem_ready = 1'b0;
    waits = 0;
    irw_seen = 1'b0;
    while (waits < 40) begin
      #1;
      if (mem_err) break;
      irw_seen |= ir_write;
      waits++;
      tick();
    end
    chk("fetch_tmo_waits", 32'(waits), 32'd15);
    chk("fetch_tmo_no_irw", 32'(irw_seen), 32'd0);
    chk("fetch_tmo_req_drop", 32'(mem_req), 32'd0);
    tick();

    run(6'h23, 19, 32'h7, 1'b0);
    chk("rd_tmo_refetch", 32'({trace[0].st[3:0], trace[0].mreq}), 32'h01);
    chk("rd_tmo_last_wait", 32'(trace[17].st), 32'd3);
    chk("rd_tmo_err", 32'({trace[18].err, trace[18].mreq}), 32'h2);
    chk("rd_tmo_state", 32'(trace[18].st), 32'd0);
    chk("rd_tmo_no_wb", 32'(trace[18].rw | trace[17].rw), 32'd0);

    run(6'h2b, 4, 32'h7, 1'b0);
    #1;
    chk("memwr_state", 32'(state), 32'd5);
    chk("memwr_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_req", 32'({mem_req, mem_we}), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    tick(); tick();
    mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_release", 32'({state, mem_req}), 32'h01);
    run(6'h02, 3, '1, 1'b0);
    chk_path("arst_j_path", 3, 64'hB10);

    tick(); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
